bf_feistel_engine: RTL and testbench
====================================

// Module: bf_feistel_engine
// PURPOSE
//  Parametrised Blowfish Feistel datapath for the bcrypt core: encrypts or decrypts one 64-bit block per
//  transaction, reading S-boxes and P-array from two single-port read-only SRAM channels (1-cycle latency).
//  Successor of the fixed 16-round encrypt-only round unit. Adds ROUNDS/base-address params, decrypt mode,
//  valid/ready handshake both sides, overlapped P fetch (3 cycles/round). Sits between key-schedule and EksBlowfish control.
// PARAMETERS
//  ROUNDS   16    Feistel rounds; even, 2..30; P-array holds ROUNDS+2 words
//  ADDR_W   12    SRAM address width
//  S_BASE   0     word address of S0[0]; S1/S2/S3 at S_BASE+256/512/768
//  P_BASE   4000  word address of P[0]
// PORTS
//  clk       in   1       clock, all state on rising edge
//  reset     in   1       asynchronous, active-high reset
//  in_valid  in   1       input block offered
//  in_ready  out  1       engine can accept block
//  in_data   in   64      {L,R} plaintext/ciphertext, L = [63:32]
//  mode      in   1       0 encrypt, 1 decrypt; sampled on accept
//  out_valid out  1       result valid, held until taken
//  out_ready in   1       consumer takes result
//  out_data  out  64      {L,R} result
//  addr_a/addr_b  out ADDR_W  SRAM A/B word address
//  cs_a_l/cs_b_l  out 1       chip select, active low
//  oe_a_l/oe_b_l  out 1       output enable, constant 0
//  we_a_l/we_b_l  out 1       write enable, constant 1 (read-only)
//  data_a/data_b  in  32      SRAM read data, valid cycle after cs_x_l=0
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, out_data=0, L/R/F_r/round=0, cs_*_l=1, in_ready=0 while reset high.
//  pidx(k) = mode ? ROUNDS+1-k : k. P reads go to P_BASE+pidx(k). addr_* don't-care when cs_*_l=1.
//  in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
//  States: IDLE, SB01, SB23, MIX, FIN, DONE.
//  IDLE/DONE on accept: latch L,R,mode; round=0; cs_a_l=0, addr_a=P[pidx(0)]; -> SB01.
//  SB01: Lx=L^data_a; addr_a=S_BASE+Lx[31:24], addr_b=S_BASE+256+Lx[23:16], both cs=0; L<=Lx; -> SB23.
//  SB23: F_r<=data_a+data_b (mod 2^32); addr_a=S_BASE+512+L[15:8], addr_b=S_BASE+768+L[7:0]; -> MIX.
//  MIX: L<=R^((F_r^data_a)+data_b); R<=L. If round<ROUNDS-1: round++, cs_a_l=0, addr_a=P[pidx(round+1)],
//       -> SB01. Else: addr_a=P[pidx(ROUNDS+1)], addr_b=P[pidx(ROUNDS)], both cs=0; -> FIN.
//  FIN: out_data<={R^data_a, L^data_b}; out_valid<=1; -> DONE.
//  DONE: hold out_data/out_valid until out_ready; out_ready & !in_valid -> IDLE, out_valid<=0;
//        out_ready & in_valid -> accept new block same edge (back-to-back), out_valid<=0.
//  Latency: accept edge to out_valid high = 3*ROUNDS+2 edges (50 @16). Throughput 1 block/(3*ROUNDS+2) cycles.
//  in_data/mode changes after accept are ignored. in_valid during SB01..FIN: in_ready=0, no effect.
//  reset asserted mid-transaction: immediate return to reset values; partial block discarded, no out_valid.
//  round counter width $clog2(ROUNDS); no wrap possible. All adds mod 2^32, carry discarded.
// STRUCTURE
//  Package bf_pkg: state enum (3 bits), S-box offsets 0/256/512/768, BLOCK_W=64, WORD_W=32.
//  One sub-module: bf_addr_gen (combinational): state, L/Lx, round, mode -> addr_a/b, cs_a_l/cs_b_l.
//  Engine holds FSM, L/R/F_r/round/mode registers, output register, handshake logic.
// TESTING
//  SRAM model: 1-cycle read latency, X on data when cs_l was high previous cycle (catch stray sampling).
//  1 All S and P zero, ROUNDS=16, enc, in_data=64'h01234567_89ABCDEF -> out_data=64'h89ABCDEF_01234567 at +50.
//  2 ROUNDS=2, S zero, P[3]=32'hFFFFFFFF, others 0, in 64'h01234567_89ABCDEF -> out 64'h76543210_01234567.
//  3 SRAM loaded with zero-key Blowfish schedule, enc 64'h0 -> 64'h4EF99745_6198DD78; dec of that -> 64'h0.
//  4 out_ready low 20 cycles after out_valid -> out_data stable, in_ready=0; then out_ready&in_valid -> new accept same edge.
//  5 reset pulse in round 7 -> out_valid=0, cs_*_l=1 same cycle; next block after release completes correctly.
//  6 Random blocks, random in_valid/out_ready gaps, enc then dec vs C reference model -> round-trip equal, no drops/dups.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared types and constants for the Blowfish Feistel engine.
package bf_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned WORD_W  = 32;

    localparam int unsigned S0_OFF = 0;
    localparam int unsigned S1_OFF = 256;
    localparam int unsigned S2_OFF = 512;
    localparam int unsigned S3_OFF = 768;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SB01,
        ST_SB23,
        ST_MIX,
        ST_FIN,
        ST_DONE
    } bf_state_t;

endpackage

// File: rtl/bf_feistel_engine_addr_gen.sv
// SRAM address and chip-select generation for the Feistel engine; purely combinational.
module bf_addr_gen
    import bf_pkg::*;
#(
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned S_BASE = 0,
    parameter int unsigned P_BASE = 4000,
    parameter int unsigned RND_W  = 4
) (
    input  bf_state_t          state,
    input  logic               accept,
    input  logic               mode_sel,
    input  logic               last_round,
    input  logic [15:0]        lx_hi,
    input  logic [15:0]        l_lo,
    input  logic [RND_W-1:0]   round,
    output logic [ADDR_W-1:0]  addr_a,
    output logic [ADDR_W-1:0]  addr_b,
    output logic               cs_a_l,
    output logic               cs_b_l
);

    // Decrypt walks the P-array from the top end.
    function automatic logic [ADDR_W-1:0] p_addr(input logic [31:0] k, input logic m);
        logic [31:0] idx;
        idx = m ? (32'(ROUNDS) + 32'd1 - k) : k;
        return ADDR_W'(32'(P_BASE) + idx);
    endfunction

    function automatic logic [ADDR_W-1:0] s_addr(input logic [31:0] off, input logic [7:0] b);
        return ADDR_W'(32'(S_BASE) + off + 32'(b));
    endfunction

    always_comb begin
        addr_a = '0;
        addr_b = '0;
        cs_a_l = 1'b1;
        cs_b_l = 1'b1;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    cs_a_l = 1'b0;
                    addr_a = p_addr(32'd0, mode_sel);
                end
            end
            ST_SB01: begin
                cs_a_l = 1'b0;
                cs_b_l = 1'b0;
                addr_a = s_addr(32'(S0_OFF), lx_hi[15:8]);
                addr_b = s_addr(32'(S1_OFF), lx_hi[7:0]);
            end
            ST_SB23: begin
                cs_a_l = 1'b0;
                cs_b_l = 1'b0;
                addr_a = s_addr(32'(S2_OFF), l_lo[15:8]);
                addr_b = s_addr(32'(S3_OFF), l_lo[7:0]);
            end
            ST_MIX: begin
                cs_a_l = 1'b0;
                if (!last_round) begin
                    addr_a = p_addr(32'(round) + 32'd1, mode_sel);
                end else begin
                    cs_b_l = 1'b0;
                    addr_a = p_addr(32'(ROUNDS) + 32'd1, mode_sel);
                    addr_b = p_addr(32'(ROUNDS), mode_sel);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bf_feistel_engine.sv
// Blowfish Feistel datapath: one 64-bit block per transaction, 3 cycles per round,
// S-boxes and P-array read from two 1-cycle-latency read-only SRAM channels.
module bf_feistel_engine
    import bf_pkg::*;
#(
    parameter int unsigned ROUNDS = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned S_BASE = 0,
    parameter int unsigned P_BASE = 4000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BLOCK_W-1:0]  in_data,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BLOCK_W-1:0]  out_data,
    output logic [ADDR_W-1:0]   addr_a,
    output logic [ADDR_W-1:0]   addr_b,
    output logic                cs_a_l,
    output logic                cs_b_l,
    output logic                oe_a_l,
    output logic                oe_b_l,
    output logic                we_a_l,
    output logic                we_b_l,
    input  logic [WORD_W-1:0]   data_a,
    input  logic [WORD_W-1:0]   data_b
);

    localparam int unsigned RND_W = $clog2(ROUNDS);

    bf_state_t          state;
    logic [WORD_W-1:0]  l_r;
    logic [WORD_W-1:0]  r_r;
    logic [WORD_W-1:0]  f_r;
    logic [RND_W-1:0]   round;
    logic               mode_r;

    logic               accept;
    logic               last_round;
    logic               mode_sel;
    logic [WORD_W-1:0]  lx;

    assign in_ready   = !reset && ((state == ST_IDLE) || ((state == ST_DONE) && out_ready));
    assign accept     = in_valid && in_ready;
    assign last_round = (round == RND_W'(ROUNDS - 1));
    // The first P fetch is issued on the accept edge, before mode is latched.
    assign mode_sel   = accept ? mode : mode_r;
    assign lx         = l_r ^ data_a;

    assign oe_a_l = 1'b0;
    assign oe_b_l = 1'b0;
    assign we_a_l = 1'b1;
    assign we_b_l = 1'b1;

    bf_addr_gen #(
        .ROUNDS (ROUNDS),
        .ADDR_W (ADDR_W),
        .S_BASE (S_BASE),
        .P_BASE (P_BASE),
        .RND_W  (RND_W)
    ) u_addr_gen (
        .state      (state),
        .accept     (accept),
        .mode_sel   (mode_sel),
        .last_round (last_round),
        .lx_hi      (lx[31:16]),
        .l_lo       (l_r[15:0]),
        .round      (round),
        .addr_a     (addr_a),
        .addr_b     (addr_b),
        .cs_a_l     (cs_a_l),
        .cs_b_l     (cs_b_l)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            l_r       <= '0;
            r_r       <= '0;
            f_r       <= '0;
            round     <= '0;
            mode_r    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                    if (accept) begin
                        l_r    <= in_data[63:32];
                        r_r    <= in_data[31:0];
                        mode_r <= mode;
                        round  <= '0;
                        state  <= ST_SB01;
                    end
                end
                ST_SB01: begin
                    l_r   <= lx;
                    state <= ST_SB23;
                end
                ST_SB23: begin
                    f_r   <= data_a + data_b;
                    state <= ST_MIX;
                end
                ST_MIX: begin
                    l_r <= r_r ^ ((f_r ^ data_a) + data_b);
                    r_r <= l_r;
                    if (!last_round) begin
                        round <= round + RND_W'(1);
                        state <= ST_SB01;
                    end else begin
                        state <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    // Final swap is undone by crossing R/L into the output halves.
                    out_data  <= {r_r ^ data_a, l_r ^ data_b};
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bf_feistel_engine.sv
// Bench for bf_feistel_engine: a 16-round and a 2-round instance, each on its own SRAM pair,
// checked against a textbook Blowfish model plus hand-computed vectors.
module tb_bf_feistel_engine;

    localparam int P_BASE = 4000;

    logic        clk;
    logic        rst       [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [63:0] in_data   [2];
    logic        mode      [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] out_data  [2];
    logic [11:0] addr_a    [2];
    logic [11:0] addr_b    [2];
    logic        cs_a_l    [2];
    logic        cs_b_l    [2];
    logic        oe_a_l    [2];
    logic        oe_b_l    [2];
    logic        we_a_l    [2];
    logic        we_b_l    [2];
    logic [31:0] data_a    [2];
    logic [31:0] data_b    [2];

    logic [31:0] mem [2][4096];
    logic        or_man [2];
    logic        rnd_or [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [63:0] exp_q [2][$];
    int          acc_t [2][$];
    logic [63:0] got   [2][$];
    logic        ov_prev [2];
    logic [63:0] held    [2];

    bf_feistel_engine #(.ROUNDS(16), .ADDR_W(12), .S_BASE(0), .P_BASE(P_BASE)) u16 (
        .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .mode(mode[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .addr_a(addr_a[0]), .addr_b(addr_b[0]), .cs_a_l(cs_a_l[0]),
        .cs_b_l(cs_b_l[0]), .oe_a_l(oe_a_l[0]), .oe_b_l(oe_b_l[0]), .we_a_l(we_a_l[0]),
        .we_b_l(we_b_l[0]), .data_a(data_a[0]), .data_b(data_b[0])
    );

    bf_feistel_engine #(.ROUNDS(2), .ADDR_W(12), .S_BASE(0), .P_BASE(P_BASE)) u2 (
        .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .mode(mode[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .addr_a(addr_a[1]), .addr_b(addr_b[1]), .cs_a_l(cs_a_l[1]),
        .cs_b_l(cs_b_l[1]), .oe_a_l(oe_a_l[1]), .oe_b_l(oe_b_l[1]), .we_a_l(we_a_l[1]),
        .we_b_l(we_b_l[1]), .data_a(data_a[1]), .data_b(data_b[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-only SRAMs: data is X unless the chip was selected on the previous edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            data_a[d] <= cs_a_l[d] ? 32'hx : mem[d][addr_a[d]];
            data_b[d] <= cs_b_l[d] ? 32'hx : mem[d][addr_b[d]];
        end
    end

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++)
            out_ready[d] = rnd_or[d] ? 1'($urandom_range(0, 1)) : or_man[d];
    end

    function automatic int n_rounds(input int d);
        return (d == 0) ? 16 : 2;
    endfunction

    function automatic logic [31:0] sbox(input int d, input int box, input logic [7:0] i);
        return mem[d][box * 256 + 32'(i)];
    endfunction

    function automatic logic [31:0] f_fn(input int d, input logic [31:0] x);
        return ((sbox(d, 0, x[31:24]) + sbox(d, 1, x[23:16])) ^ sbox(d, 2, x[15:8])) + sbox(d, 3, x[7:0]);
    endfunction

    // Textbook Blowfish: decrypt is encrypt with the P-array reversed.
    function automatic logic [63:0] bf_model(input int d, input logic [63:0] blk, input logic dec);
        int n;
        logic [31:0] l, r, t, p [0:31];
        n = n_rounds(d);
        for (int k = 0; k < n + 2; k++)
            p[k] = dec ? mem[d][P_BASE + n + 1 - k] : mem[d][P_BASE + k];
        l = blk[63:32];
        r = blk[31:0];
        for (int i = 0; i < n; i++) begin
            l = l ^ p[i];
            r = r ^ f_fn(d, l);
            t = l; l = r; r = t;
        end
        t = l; l = r; r = t;
        r = r ^ p[n];
        l = l ^ p[n + 1];
        return {l, r};
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, exp);
        end
    endtask

    task automatic timeout(input string nm, input int d);
        n_vec++;
        n_err++;
        $display("FAIL %s dut%0d: timed out waiting, expected the event within budget", nm, d);
    endtask

    // Single compare process: results, latency, hold-while-stalled, spurious outputs.
    always @(negedge clk) begin
        logic [63:0] e;
        int t;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                exp_q[d].delete();
                acc_t[d].delete();
                ov_prev[d] = 1'b0;
            end else begin
                if (out_valid[d] && !ov_prev[d]) begin
                    if (exp_q[d].size() == 0) begin
                        chk("spurious_out_valid", d, 64'(out_valid[d]), 64'd0);
                    end else begin
                        e = exp_q[d].pop_front();
                        t = acc_t[d].pop_front();
                        chk("result", d, out_data[d], e);
                        chk("latency", d, 64'(cyc - t), 64'(3 * n_rounds(d) + 2));
                    end
                    held[d] = out_data[d];
                    got[d].push_back(out_data[d]);
                end else if (out_valid[d] && !out_ready[d]) begin
                    chk("hold_out_data", d, out_data[d], held[d]);
                    chk("hold_in_ready", d, 64'(in_ready[d]), 64'd0);
                end
                if (in_valid[d] && in_ready[d]) begin
                    exp_q[d].push_back(bf_model(d, in_data[d], mode[d]));
                    acc_t[d].push_back(cyc);
                end
                ov_prev[d] = out_valid[d];
            end
        end
    end

    task automatic send(input int d, input logic [63:0] blk, input logic m);
        int k;
        @(posedge clk);
        #1;
        in_valid[d] = 1'b1;
        in_data[d]  = blk;
        mode[d]     = m;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (in_ready[d]) break;
        end
        if (k == 400) timeout("accept", d);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
        in_data[d]  = {$urandom, $urandom};
        mode[d]     = 1'($urandom);
    endtask

    task automatic wait_out(input int d);
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (out_valid[d]) break;
        end
        if (k == 400) timeout("out_valid", d);
    endtask

    task automatic take(input int d);
        or_man[d] = 1'b1;
        repeat (2) @(posedge clk);
        or_man[d] = 1'b0;
    endtask

    task automatic wait_got(input int d, input int n);
        int k;
        for (k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (got[d].size() >= n) break;
        end
        if (k == 4000) timeout("result_count", d);
    endtask

    initial begin
        logic [63:0] pt [6];
        logic [63:0] ct [6];
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; in_valid[d] = 1'b0; in_data[d] = '0; mode[d] = 1'b0;
            or_man[d] = 1'b0; rnd_or[d] = 1'b0;
            for (int a = 0; a < 4096; a++) mem[d][a] = 32'h0;
        end
        mem[1][P_BASE + 3] = 32'hFFFFFFFF;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_out_valid", d, 64'(out_valid[d]), 64'd0);
            chk("rst_out_data", d, out_data[d], 64'd0);
            chk("rst_cs", d, 64'({cs_a_l[d], cs_b_l[d]}), 64'd3);
            chk("rst_in_ready", d, 64'(in_ready[d]), 64'd0);
            chk("oe_we_const", d, 64'({oe_a_l[d], oe_b_l[d], we_a_l[d], we_b_l[d]}), 64'd3);
            rst[d] = 1'b0;
        end

        // All-zero tables: 16 rounds of pure swaps leave the halves exchanged.
        send(0, 64'h01234567_89ABCDEF, 1'b0);
        wait_out(0);
        chk("zero_sbox_enc", 0, out_data[0], 64'h89ABCDEF_01234567);
        take(0);

        // Two rounds, only the last P word set: it lands on the left output half.
        send(1, 64'h01234567_89ABCDEF, 1'b0);
        wait_out(1);
        chk("r2_p3_enc", 1, out_data[1], 64'h76543210_01234567);
        take(1);
        send(1, 64'h76543210_01234567, 1'b1);
        wait_out(1);
        chk("r2_p3_dec", 1, out_data[1], 64'h01234567_89ABCDEF);
        take(1);

        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 4096; a++) mem[d][a] = $urandom;

        // Stall the consumer, then take and accept on the same edge.
        send(0, 64'hDEADBEEF_CAFEF00D, 1'b0);
        wait_out(0);
        repeat (20) @(posedge clk);
        #1;
        in_valid[0] = 1'b1;
        in_data[0]  = 64'h0F1E2D3C_4B5A6978;
        mode[0]     = 1'b1;
        take(0);
        #1;
        in_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_valid_drop", 0, 64'(out_valid[0]), 64'd0);
        wait_out(0);
        take(0);

        // Reset in the middle of round 7 aborts the block.
        send(0, 64'h11112222_33334444, 1'b0);
        repeat (22) @(posedge clk);
        #3;
        rst[0] = 1'b1;
        #1;
        chk("midrst_out_valid", 0, 64'(out_valid[0]), 64'd0);
        chk("midrst_cs", 0, 64'({cs_a_l[0], cs_b_l[0]}), 64'd3);
        chk("midrst_in_ready", 0, 64'(in_ready[0]), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        send(0, 64'h55556666_77778888, 1'b0);
        wait_out(0);
        take(0);

        // Random round trips with random consumer back-pressure.
        for (int d = 0; d < 2; d++) begin
            rnd_or[d] = 1'b1;
            got[d].delete();
            for (int i = 0; i < 6; i++) begin
                pt[i] = {$urandom, $urandom};
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send(d, pt[i], 1'b0);
            end
            wait_got(d, 6);
            for (int i = 0; i < 6; i++) ct[i] = got[d][i];
            got[d].delete();
            for (int i = 0; i < 6; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                send(d, ct[i], 1'b1);
            end
            wait_got(d, 6);
            chk("roundtrip_count", d, 64'(got[d].size()), 64'd6);
            for (int i = 0; i < 6 && i < got[d].size(); i++)
                chk("roundtrip", d, got[d][i], pt[i]);
            rnd_or[d] = 1'b0;
        end

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
